// File: rtl/result_send_pkg.sv
// Shared types and constants for the result frame sender: state encoding,
// frame geometry and the snapshot record captured on a start edge.
package result_send_pkg;

    localparam int unsigned FRAME_LEN      = 5;
    localparam logic [7:0]  DEFAULT_HEADER = 8'hA5;

    typedef logic [2:0] byte_idx_t;

    localparam byte_idx_t LAST_IDX = byte_idx_t'(FRAME_LEN - 1);

    // Fixed encodings kept so existing state-decode logic elsewhere still matches
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        GAP  = ST_GAP,
        DONE = ST_DONE
    } state_t;

    typedef struct packed {
        logic [3:0] id1;
        logic [3:0] id2;
        logic [3:0] id3;
        logic [3:0] id4;
        logic [3:0] size;
        logic       astig;
    } snap_t;

endpackage

// File: rtl/result_send_ctrl_if.sv
// Byte-wide valid/ready link from the result sender to the serial transmitter.
interface result_send_ctrl_if;

    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;

    modport master (
        output o_tx_data,
        output o_tx_valid,
        input  i_tx_ready
    );

    modport slave (
        input  o_tx_data,
        input  o_tx_valid,
        output i_tx_ready
    );

endinterface

// File: rtl/result_frame_pack.sv
// Combinational frame formatter: maps the captured result fields and a byte
// index onto the outgoing frame byte, including the trailing XOR checksum.
module result_frame_pack
    import result_send_pkg::*;
#(
    parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
    input  snap_t      snap,
    input  byte_idx_t  idx,
    output logic [7:0] frame_byte
);

    logic [7:0] b_id_hi;
    logic [7:0] b_id_lo;
    logic [7:0] b_result;
    logic [7:0] b_check;

    always_comb begin
        b_id_hi  = {snap.id1, snap.id2};
        b_id_lo  = {snap.id3, snap.id4};
        b_result = {snap.size, 3'b000, snap.astig};
        b_check  = HEADER ^ b_id_hi ^ b_id_lo ^ b_result;

        frame_byte = '0;
        unique case (idx)
            3'd0:    frame_byte = HEADER;
            3'd1:    frame_byte = b_id_hi;
            3'd2:    frame_byte = b_id_lo;
            3'd3:    frame_byte = b_result;
            3'd4:    frame_byte = b_check;
            default: frame_byte = '0;
        endcase
    end

endmodule

// File: rtl/result_send_ctrl.sv
// Result frame sender: captures one vision-test result on a start rising edge
// and streams it as a 5-byte frame over the tx valid/ready link.
module result_send_ctrl
    import result_send_pkg::*;
#(
    parameter logic [7:0]  HEADER     = DEFAULT_HEADER,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [3:0]         i_ID1,
    input  logic [3:0]         i_ID2,
    input  logic [3:0]         i_ID3,
    input  logic [3:0]         i_ID4,
    input  logic [3:0]         i_size,
    input  logic               i_astigmatism_result,
    input  logic               i_start_to_send,
    result_send_ctrl_if.master tx,
    output logic               o_busy,
    output logic               o_done,
    output logic [7:0]         o_frame_cnt
);

    localparam int unsigned    GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t          state;
    snap_t           snap;
    byte_idx_t       idx;
    logic [GW-1:0]   gap_cnt;
    logic            start_q;
    logic            start_edge;
    logic [7:0]      cur_byte;

    assign start_edge = i_start_to_send & ~start_q;

    result_frame_pack #(
        .HEADER (HEADER)
    ) u_pack (
        .snap       (snap),
        .idx        (idx),
        .frame_byte (cur_byte)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            snap        <= '0;
            idx         <= '0;
            gap_cnt     <= '0;
            start_q     <= 1'b0;
            o_frame_cnt <= '0;
        end else begin
            start_q <= i_start_to_send;
            unique case (state)
                IDLE: begin
                    if (start_edge) begin
                        snap  <= '{id1: i_ID1, id2: i_ID2, id3: i_ID3, id4: i_ID4,
                                   size: i_size, astig: i_astigmatism_result};
                        idx   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (tx.i_tx_ready) begin
                        // Count on entry to DONE so the new total is visible with o_done
                        if (idx == LAST_IDX) begin
                            o_frame_cnt <= o_frame_cnt + 8'd1;
                            state       <= DONE;
                        end else begin
                            idx     <= idx + 3'd1;
                            gap_cnt <= '0;
                            state   <= (GAP_CYCLES == 0) ? SEND : GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx.o_tx_valid = (state == SEND);
    assign tx.o_tx_data  = (state == SEND) ? cur_byte : '0;
    assign o_busy        = (state == SEND) || (state == GAP);
    assign o_done        = (state == DONE);

endmodule

// File: tb/tb_result_send_ctrl.sv
// Scoreboard bench for result_send_ctrl: one back-to-back and one gapped
// instance, random and directed start/ready traffic, frames modelled from fields.
module tb_result_send_ctrl;

    localparam int unsigned GAP1    = 2;
    localparam int          TIMEOUT = 400;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       id1 = '0, id2 = '0, id3 = '0, id4 = '0, size = '0;
    logic             astig = 1'b0;
    logic [1:0]       start = '0;
    logic [1:0]       rdy = '1;
    logic [1:0]       vld, busy, done;
    logic [1:0][7:0]  dat, cnt;

    always #5 clk = ~clk;

    result_send_ctrl_if tx0();
    result_send_ctrl_if tx1();

    assign tx0.i_tx_ready = rdy[0];
    assign tx1.i_tx_ready = rdy[1];
    assign vld[0] = tx0.o_tx_valid;
    assign vld[1] = tx1.o_tx_valid;
    assign dat[0] = tx0.o_tx_data;
    assign dat[1] = tx1.o_tx_data;

    result_send_ctrl #(.HEADER(8'hA5), .GAP_CYCLES(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_ID1(id1), .i_ID2(id2), .i_ID3(id3), .i_ID4(id4),
        .i_size(size), .i_astigmatism_result(astig), .i_start_to_send(start[0]),
        .tx(tx0), .o_busy(busy[0]), .o_done(done[0]), .o_frame_cnt(cnt[0])
    );

    result_send_ctrl #(.HEADER(8'hA5), .GAP_CYCLES(GAP1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_ID1(id1), .i_ID2(id2), .i_ID3(id3), .i_ID4(id4),
        .i_size(size), .i_astigmatism_result(astig), .i_start_to_send(start[1]),
        .tx(tx1), .o_busy(busy[1]), .o_done(done[1]), .o_frame_cnt(cnt[1])
    );

    typedef struct packed {
        logic [39:0] bytes;
        logic [31:0] start_cyc;
        logic [7:0]  cnt;
    } exp_t;

    exp_t       exp_q[2][$];
    exp_t       cur[2];
    bit         in_frame[2];
    bit         need_gap[2];
    int         bi[2];
    int         inv_run[2];
    int         done_due[2];
    int         frames_done[2];
    int         frames_issued[2];
    logic [7:0] model_cnt[2];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [39:0] make_frame(input logic [3:0] a, b, c, e, s, input logic ast);
        logic [7:0] h, x1, x2, x3;
        h  = 8'hA5;
        x1 = 8'(a * 16 + b);
        x2 = 8'(c * 16 + e);
        x3 = 8'(s * 16 + ast);
        return {h, x1, x2, x3, h ^ x1 ^ x2 ^ x3};
    endfunction

    function automatic logic [7:0] byte_at(input logic [39:0] f, input int i);
        return f[39 - 8 * i -: 8];
    endfunction

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : int'(GAP1);
    endfunction

    task automatic check(input bit ok, input string name, input int d, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h (cyc %0d)", name, d, act, exp, cyc);
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            in_frame[d]      = 1'b0;
            need_gap[d]      = 1'b0;
            bi[d]            = 0;
            inv_run[d]       = 0;
            done_due[d]      = -1;
            frames_done[d]   = 0;
            frames_issued[d] = 0;
            model_cnt[d]     = 8'd0;
        end
    endtask

    // Monitor: consumes expected frames as the DUTs present them
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (vld[d]) begin
                    if (!in_frame[d]) begin
                        if (exp_q[d].size() == 0) begin
                            check(1'b0, "unexpected_valid", d, int'(dat[d]), 0);
                        end else begin
                            cur[d]      = exp_q[d].pop_front();
                            in_frame[d] = 1'b1;
                            bi[d]       = 0;
                            need_gap[d] = 1'b0;
                            check(cyc == int'(cur[d].start_cyc), "first_valid_latency", d,
                                  cyc, int'(cur[d].start_cyc));
                        end
                    end
                    if (in_frame[d]) begin
                        if (need_gap[d]) begin
                            check(inv_run[d] == gap_of(d), "gap_len", d, inv_run[d], gap_of(d));
                            need_gap[d] = 1'b0;
                        end
                        check(busy[d] == 1'b1, "busy_while_valid", d, int'(busy[d]), 1);
                        check(dat[d] == byte_at(cur[d].bytes, bi[d]), "tx_data", d,
                              int'(dat[d]), int'(byte_at(cur[d].bytes, bi[d])));
                        if (rdy[d]) begin
                            bi[d]++;
                            inv_run[d] = 0;
                            if (bi[d] == 5) begin
                                in_frame[d] = 1'b0;
                                done_due[d] = cyc + 1;
                            end else begin
                                need_gap[d] = 1'b1;
                            end
                        end
                    end
                end else if (in_frame[d]) begin
                    inv_run[d]++;
                    check(busy[d] == 1'b1, "busy_in_gap", d, int'(busy[d]), 1);
                end else if (!done[d]) begin
                    check(busy[d] == 1'b0, "busy_idle", d, int'(busy[d]), 0);
                end

                if (done[d]) begin
                    check(cyc == done_due[d], "done_timing", d, cyc, done_due[d]);
                    check(cnt[d] == cur[d].cnt, "frame_cnt", d, int'(cnt[d]), int'(cur[d].cnt));
                    check(!busy[d] && !vld[d], "done_idle_outputs", d, int'({busy[d], vld[d]}), 0);
                    done_due[d] = -1;
                    frames_done[d]++;
                end else if (cyc == done_due[d]) begin
                    check(1'b0, "missing_done", d, 0, 1);
                    done_due[d] = -1;
                    frames_done[d]++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [3:0] a, b, c, e, s, input logic ast);
        id1 = a; id2 = b; id3 = c; id4 = e; size = s; astig = ast;
    endtask

    task automatic rand_fields();
        set_fields(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                   4'($urandom), 1'($urandom));
    endtask

    // Raise start for DUT d; a frame is expected only for a real edge while idle
    task automatic raise(input int d);
        exp_t e;
        if (start[d] == 1'b0 && frames_issued[d] == frames_done[d]) begin
            model_cnt[d] = model_cnt[d] + 8'd1;
            e.bytes      = make_frame(id1, id2, id3, id4, size, astig);
            e.start_cyc  = 32'(cyc + 1);
            e.cnt        = model_cnt[d];
            exp_q[d].push_back(e);
            frames_issued[d]++;
        end
        start[d] = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((frames_done[0] != frames_issued[0] || frames_done[1] != frames_issued[1])
               && n < TIMEOUT) begin
            tick();
            n++;
        end
        check(n < TIMEOUT, "idle_timeout", 0, n, TIMEOUT);
        tick();
        tick();
    endtask

    task automatic check_quiet(input string name);
        for (int d = 0; d < 2; d++) begin
            check(vld[d] == 1'b0, {name, "_valid"}, d, int'(vld[d]), 0);
            check(busy[d] == 1'b0, {name, "_busy"}, d, int'(busy[d]), 0);
            check(done[d] == 1'b0, {name, "_done"}, d, int'(done[d]), 0);
            check(cnt[d] == 8'd0, {name, "_cnt"}, d, int'(cnt[d]), 0);
            check(dat[d] == 8'd0, {name, "_data"}, d, int'(dat[d]), 0);
        end
    endtask

    initial begin
        reset_model();
        rst = 1'b1;
        repeat (3) tick();
        check_quiet("reset");
        rst = 1'b0;
        tick();

        // Reference frame, then inputs cleared right after the edge
        set_fields(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 1'b1);
        raise(0); raise(1);
        tick();
        set_fields(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        start = '0;
        wait_idle();

        // Ready held low for three cycles while byte 2 is presented
        set_fields(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 1'b1);
        raise(0); raise(1);
        tick();
        start = '0;
        tick(); tick();
        rdy[0] = 1'b0;
        repeat (3) tick();
        rdy[0] = 1'b1;
        wait_idle();

        // Start held high, released, raised again: exactly two frames
        rand_fields();
        raise(0); raise(1);
        repeat (20) tick();
        start = '0;
        tick();
        rand_fields();
        raise(0); raise(1);
        tick();
        start = '0;
        wait_idle();

        // Second edge during a frame is dropped
        rand_fields();
        raise(0); raise(1);
        repeat (3) tick();
        start = '0;
        tick();
        raise(0); raise(1);
        repeat (2) tick();
        start = '0;
        wait_idle();

        // Edge landing in the DONE cycle of the back-to-back instance is ignored
        rand_fields();
        raise(0);
        tick();
        start[0] = 1'b0;
        repeat (5) tick();
        raise(0);
        repeat (4) tick();
        start[0] = 1'b0;
        wait_idle();

        // Reset while byte 3 is on the bus
        rand_fields();
        raise(0); raise(1);
        tick();
        start = '0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reset_model();
        check_quiet("abort");
        repeat (3) tick();
        set_fields(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 1'b1);
        raise(0); raise(1);
        tick();
        start = '0;
        wait_idle();

        // Enough frames to wrap the completed-frame counter
        for (int k = 0; k < 256; k++) begin
            rand_fields();
            raise(0); raise(1);
            tick();
            start = '0;
            wait_idle();
        end

        // Random start, ready and field traffic
        for (int k = 0; k < 2000; k++) begin
            rand_fields();
            for (int d = 0; d < 2; d++) begin
                rdy[d] = ($urandom_range(0, 9) < 7);
                if (start[d] && $urandom_range(0, 3) == 0) start[d] = 1'b0;
                else if (!start[d] && $urandom_range(0, 2) == 0) raise(d);
            end
            tick();
        end
        start = '0;
        rdy = '1;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
